// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage segmented adder with per-segment
// carry approximation, valid/ready handshake and an error counter.
module approx_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  localparam int NSEG = WIDTH / SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [NSEG-2:0]  mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             err,
  input  logic             clr_cnt,
  output logic [15:0]      err_cnt
);

  logic                     rdy_en;
  logic                     s2_adv;
  logic                     accept;
  logic                     xfer;

  logic [NSEG-1:0][SEG:0]   sum0;
  logic [NSEG-1:0][SEG:0]   sum1;
  logic [NSEG-1:0]          gen;
  logic [WIDTH:0]           exact;

  logic                     s1_valid;
  logic [NSEG-2:0]          s1_mask;
  logic [NSEG-1:0][SEG:0]   s1_sum0;
  logic [NSEG-1:0][SEG:0]   s1_sum1;
  logic [NSEG-1:0]          s1_gen;
  logic [WIDTH:0]           s1_exact;

  logic [NSEG-1:0]          mext;
  logic [SEG:0]             seg;
  logic                     c;
  logic [WIDTH-1:0]         sel_out;
  logic                     sel_cout;
  logic                     sel_err;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = rdy_en && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign mext     = {1'b0, s1_mask};

  // Ready is held low in reset and opens on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Per-segment sums for both carry-in values, MSB generates, exact sum.
  always_comb begin
    sum0  = '0;
    sum1  = '0;
    gen   = '0;
    for (int i = 0; i < NSEG; i++) begin
      sum0[i] = {1'b0, in1[i*SEG +: SEG]}
              + {1'b0, in2[i*SEG +: SEG]};
      sum1[i] = sum0[i] + (SEG+1)'(1);
      gen[i]  = in1[(i+1)*SEG-1] & in2[(i+1)*SEG-1];
    end
    exact = {1'b0, in1} + {1'b0, in2};
  end

  // Stage 1 register: loads on every slot the stage can take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_gen   <= '0;
      s1_exact <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_mask  <= mask;
        s1_sum0  <= sum0;
        s1_sum1  <= sum1;
        s1_gen   <= gen;
        s1_exact <= exact;
      end
    end
  end

  // Carry-select chain; a masked boundary uses the segment MSB generate.
  always_comb begin
    c        = 1'b0;
    seg      = '0;
    sel_out  = '0;
    sel_cout = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      seg = c ? s1_sum1[i] : s1_sum0[i];
      sel_out[i*SEG +: SEG] = seg[SEG-1:0];
      sel_cout = seg[SEG];
      c = mext[i] ? s1_gen[i] : seg[SEG];
    end
    sel_err = {sel_cout, sel_out} != s1_exact;
  end

  // Stage 2 register: result only changes when the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out  <= sel_out;
        cout <= sel_cout;
        err  <= sel_err;
      end
    end
  end

  // Saturating count of erroneous transfers; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (xfer && err && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end

endmodule
